// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch and load/store share one
// memory port, round-robin on contention, one outstanding transaction at a time.
module mem_port_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_req,
  input  logic [WORD_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [WORD_LENGTH-1:0] if_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   dbg_state
);

  // Handshake: a requester holds req until it sees its gnt; gnt and the memory
  // strobe are the same cycle, and rvalid pulses exactly MEM_LATENCY cycles later.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;

  logic idle_ok;
  logic if_win;
  logic d_win;
  logic done;

  always_comb begin
    // Reset also masks grants combinationally so nothing issues while it is held.
    idle_ok = (state_q == S_IDLE) && !reset;
    if_win  = idle_ok && if_req && (!d_req || (last_owner_q == OWN_D));
    d_win   = idle_ok && d_req && !if_win;
    done    = (state_q == S_WAIT) && (cnt_q == 4'd1);

    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_addr  = if_win ? if_addr : (d_win ? d_addr : '0);
    mem_wdata = d_win ? d_wdata : '0;
    mem_re    = if_win || (d_win && !d_we);
    mem_we    = d_win && d_we;

    if_rvalid = done && (owner_q == OWN_IF);
    d_rvalid  = done && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    dbg_state = state_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    if (if_win || d_win) begin
      state_d      = S_WAIT;
      cnt_d        = LAT;
      owner_d      = d_win ? OWN_D : OWN_IF;
      we_d         = d_win && d_we;
      last_owner_d = d_win ? OWN_D : OWN_IF;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (done) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_owner_q <= OWN_D;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 4) share stimulus and
// are checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         if_req, d_req, d_we;
  logic [W-1:0] if_addr, d_addr, d_wdata, mem_rdata;

  logic [1:0]   if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, mem_re, dbg;
  logic [W-1:0] if_rdata [2];
  logic [W-1:0] d_rdata [2];
  logic [W-1:0] mem_addr [2];
  logic [W-1:0] mem_wdata [2];

  mem_port_arbiter #(.WORD_LENGTH(W), .MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_re(mem_re[0]), .mem_rdata(mem_rdata), .dbg_state(dbg[0])
  );

  mem_port_arbiter #(.WORD_LENGTH(W), .MEM_LATENCY(4)) u_lat4 (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_re(mem_re[1]), .mem_rdata(mem_rdata), .dbg_state(dbg[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: per instance, whether a transaction is in flight, the
  // cycle on which it completes, who owns it and who won the last grant.
  bit m_busy [2];
  int m_done [2];
  bit m_is_d [2];
  bit m_store [2];
  bit m_last_d [2];

  bit log_en = 1'b0;
  bit gnt_who_q [$];
  int gnt_cyc_q [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input int k, input int lat);
    logic e_ig, e_dg, e_re, e_we, e_irv, e_drv, e_wait;
    logic [W-1:0] e_ird, e_drd, e_ma, e_mw;
    bit if_w, d_w;
    {e_ig, e_dg, e_re, e_we, e_irv, e_drv} = '0;
    {e_ird, e_drd, e_ma, e_mw} = '0;
    e_wait = 1'b0;
    if (rst) begin
      m_busy[k]   = 1'b0;
      m_last_d[k] = 1'b1;
    end else if (m_busy[k]) begin
      e_wait = 1'b1;
      if (cyc == m_done[k]) begin
        if (m_is_d[k]) begin
          e_drv = 1'b1;
          e_drd = m_store[k] ? '0 : mem_rdata;
        end else begin
          e_irv = 1'b1;
          e_ird = mem_rdata;
        end
        m_busy[k] = 1'b0;
      end
    end else begin
      if_w = if_req && (!d_req || m_last_d[k]);
      d_w  = d_req && !if_w;
      e_ig = if_w;
      e_dg = d_w;
      e_ma = if_w ? if_addr : (d_w ? d_addr : '0);
      e_mw = d_w ? d_wdata : '0;
      e_re = if_w || (d_w && !d_we);
      e_we = d_w && d_we;
      if (if_w || d_w) begin
        m_busy[k]   = 1'b1;
        m_done[k]   = cyc + lat;
        m_is_d[k]   = d_w;
        m_store[k]  = d_w && d_we;
        m_last_d[k] = d_w;
      end
    end
    check_val($sformatf("u%0d.ctl", k), {if_gnt[k], d_gnt[k], mem_re[k], mem_we[k]},
              {e_ig, e_dg, e_re, e_we});
    check_val($sformatf("u%0d.rvalid", k), {if_rvalid[k], d_rvalid[k]}, {e_irv, e_drv});
    check_val($sformatf("u%0d.if_rdata", k), if_rdata[k], e_ird);
    check_val($sformatf("u%0d.d_rdata", k), d_rdata[k], e_drd);
    check_val($sformatf("u%0d.mem_addr", k), mem_addr[k], e_ma);
    check_val($sformatf("u%0d.mem_wdata", k), mem_wdata[k], e_mw);
    check_val($sformatf("u%0d.state", k), dbg[k], e_wait);
    if (k == 0 && log_en && (if_gnt[0] || d_gnt[0])) begin
      gnt_who_q.push_back(d_gnt[0]);
      gnt_cyc_q.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, 1);
    check_dut(1, 4);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    // Requests during reset must be masked.
    if_req = 1'b1; d_req = 1'b1;
    tick();
    tick();
    idle_inputs();
    rst = 1'b0;

    // Single fetch of 0x4 returning an addi encoding.
    if_req = 1'b1; if_addr = 32'h0000_0004;
    tick();
    if_req = 1'b0; if_addr = '0; mem_rdata = 32'h0050_0093;
    tick();
    mem_rdata = '0;
    repeat (4) tick();

    // Contention right after reset release: IF, D, IF, D every other cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    log_en = 1'b1;
    c0 = cyc;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    repeat (8) begin
      mem_rdata = $urandom;
      tick();
    end
    log_en = 1'b0;
    idle_inputs();
    check_val("contend.count", 64'(gnt_who_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_who_q.size()) begin
        check_val($sformatf("contend.who%0d", i), 64'(gnt_who_q[i]), 64'(i % 2));
        check_val($sformatf("contend.cyc%0d", i), 64'(gnt_cyc_q[i] - c0), 64'(2 * i));
      end
    end
    repeat (4) tick();

    // Store: d_rdata must read 0 on completion whatever the memory returns.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    repeat (5) begin
      mem_rdata = $urandom;
      tick();
    end

    // Load request raised while a fetch is outstanding.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    if_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_0200;
    repeat (6) begin
      mem_rdata = $urandom;
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    // Reset in the middle of a load, then a contended request goes to fetch.
    d_req = 1'b1; d_addr = 32'h0000_0300;
    tick();
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) begin
      mem_rdata = $urandom;
      tick();
    end
    if_req = 1'b1; d_req = 1'b1;
    tick();
    idle_inputs();
    repeat (5) tick();

    // Quiet period.
    repeat (10) tick();

    // Randomized traffic with occasional resets.
    repeat (500) begin
      rst       = ($urandom_range(0, 59) == 0);
      if_req    = $urandom_range(0, 1);
      d_req     = $urandom_range(0, 1);
      d_we      = $urandom_range(0, 1);
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      mem_rdata = $urandom;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 32: data and address width in bits.
REQ-002 The block SHALL have parameter MEM_LATENCY, default 1, legal range 1..15: cycles from memory issue to valid read data.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named as listed below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-007 if_addr  input  WORD_LENGTH  fetch address; stable while if_req is high.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  one-cycle pulse: if_rdata valid.
REQ-010 if_rdata  output  WORD_LENGTH  fetch read data.
REQ-011 d_req  input  1  load/store request; held until d_gnt.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  WORD_LENGTH  load/store address.
REQ-014 d_wdata  input  WORD_LENGTH  store data.
REQ-015 d_gnt  output  1  load/store request accepted this cycle.
REQ-016 d_rvalid  output  1  one-cycle pulse: load data valid, or store complete.
REQ-017 d_rdata  output  WORD_LENGTH  load data; 0 on store completion.
REQ-018 mem_addr  output  WORD_LENGTH  shared memory address.
REQ-019 mem_wdata  output  WORD_LENGTH  shared memory write data.
REQ-020 mem_we  output  1  memory write strobe, issue cycle only.
REQ-021 mem_re  output  1  memory read strobe, issue cycle only.
REQ-022 mem_rdata  input  WORD_LENGTH  memory read data, valid MEM_LATENCY cycles after the issue cycle.

Function
REQ-023 The FSM SHALL have two states: IDLE and WAIT.
REQ-024 Requests SHALL be granted only in IDLE, and at most one transaction SHALL be outstanding.
REQ-025 In IDLE, if exactly one of if_req/d_req is high, that requester SHALL be granted.
REQ-026 In IDLE, if both are high, the requester not granted last SHALL be granted (round-robin on a 1-bit last_owner register).
REQ-027 Grant and issue SHALL occur in the same cycle, combinationally:
- the gnt of the winning requester is high;
- mem_addr and mem_wdata carry the winner's address and data;
- a fetch asserts mem_re;
- a load asserts mem_re;
- a store asserts mem_we.
REQ-028 At most one of if_gnt/d_gnt SHALL be high in any cycle, and mem_re/mem_we SHALL be low outside issue cycles.
REQ-029 On grant, the owner and d_we SHALL be registered, last_owner SHALL be updated, a 4-bit counter SHALL be loaded with MEM_LATENCY, and the state SHALL go to WAIT.
REQ-030 In WAIT, the counter SHALL decrement each cycle.
REQ-031 When the counter reaches 1, i.e. cycle issue+MEM_LATENCY, the block SHALL:
- pulse the owner's rvalid;
- drive the owner's rdata = mem_rdata, or d_rdata = 0 for a store;
- return to IDLE at the next edge.
REQ-032 A transaction SHALL take MEM_LATENCY+1 cycles, and the next grant SHALL come no earlier than the cycle after rvalid.
REQ-033 Requests arriving during WAIT SHALL be ignored (no gnt) and SHALL be served from IDLE per REQ-025/026.
REQ-034 The non-owner's rvalid SHALL stay low, and both rdata outputs SHALL be 0 whenever their rvalid is low.
REQ-035 if_req deasserted before grant SHALL be legal, and the block SHALL then see no request.

Reset
REQ-036 While reset is high, regardless of clk, the block SHALL hold:
- state = IDLE, counter = 0, last_owner = DATA;
- every gnt, rvalid, mem_re and mem_we = 0;
- all data outputs = 0.
REQ-037 Reset during WAIT SHALL abort the transaction with no rvalid pulse.
REQ-038 After reset, the first contended grant SHALL go to ifetch.
REQ-039 The first grant after reset release SHALL be possible on the first rising edge at which reset is low.

Verification
REQ-040 Single fetch, MEM_LATENCY=1: if_req=1, if_addr=0x0000_0004 in cycle N -> if_gnt=1, mem_re=1, mem_addr=0x4 in N; in N+1 mem_rdata=0x0050_0093 -> if_rvalid=1, if_rdata=0x0050_0093.
REQ-041 Contention after reset: if_req=d_req=1 held continuously -> grants go IF, D, IF, D at cycles N, N+2, N+4, N+6.
REQ-042 Store, MEM_LATENCY=3: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> mem_we=1 only in N; d_rvalid=1 with d_rdata=0 in N+3; no gnt in N+1..N+3.
REQ-043 Request during WAIT: d_req=1 raised in N+1 while a fetch issued in N is outstanding -> d_gnt stays low until N+2, where d_gnt=1.
REQ-044 Reset mid-transaction, MEM_LATENCY=4: reset pulse in cycle N+2 of a load -> no d_rvalid at N+4; all outputs 0; next contended grant = ifetch.
REQ-045 Idle check: no requests for 10 cycles -> mem_re, mem_we, both gnts and both rvalids stay 0 every cycle.
